// File: rtl/multi_push_fifo.sv
// Multi-push / single-pop synchronous FIFO with show-ahead read port.
// Optional sticky overflow flag `ovf` when MULTI_PUSH_FIFO_OVF_FLAG_EN is defined.
module multi_push_fifo #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PUSH_MAX   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(PUSH_MAX):0]     push_cnt,
    input  logic [DATA_WIDTH-1:0]         data_in [PUSH_MAX],
    output logic [$clog2(PUSH_MAX):0]     space_cnt,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          valid,
    output logic [$clog2(DEPTH):0]        count,
`ifdef MULTI_PUSH_FIFO_OVF_FLAG_EN
    output logic                          ovf,
`endif
    output logic                          full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(PUSH_MAX) + 1;

    logic [PW-1:0]         w_ptr_q, w_ptr_d;
    logic [PW-1:0]         r_ptr_q, r_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]         free;
    logic [CW-1:0]         acc;

    // Wrap bit makes w_ptr - r_ptr distinguish full from empty.
    assign count     = w_ptr_q - r_ptr_q;
    assign free      = PW'(DEPTH) - count;
    assign space_cnt = (free >= PW'(PUSH_MAX)) ? CW'(PUSH_MAX) : free[CW-1:0];
    assign acc       = (push_cnt < space_cnt) ? push_cnt : space_cnt;
    assign valid     = (count != '0);
    assign full      = (count == PW'(DEPTH));
    assign data_out  = mem_q[r_ptr_q[AW-1:0]];

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        mem_d   = mem_q;
        if (!rst) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
        end else begin
            for (int i = 0; i < PUSH_MAX; i++) begin
                if (CW'(i) < acc) begin
                    mem_d[w_ptr_q[AW-1:0] + AW'(i)] = data_in[i];
                end
            end
            w_ptr_d = w_ptr_q + PW'(acc);
            r_ptr_d = r_ptr_q + PW'(pop && valid);
        end
    end

    always_ff @(posedge clk) begin
        w_ptr_q <= w_ptr_d;
        r_ptr_q <= r_ptr_d;
        mem_q   <= mem_d;
    end

`ifdef MULTI_PUSH_FIFO_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (!rst) begin
            ovf_d = 1'b0;
        end else if ((push_cnt > space_cnt) || (push_cnt > CW'(PUSH_MAX))) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;

    push_cnt_in_range: assert property (@(posedge clk) disable iff (!rst)
        push_cnt <= CW'(PUSH_MAX));
`endif

endmodule

// File: tb/tb_multi_push_fifo.sv
// Self-checking bench for multi_push_fifo: directed scenarios plus random traffic
// compared against a queue-based model.
module tb_multi_push_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned PM    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    push_cnt;
    logic [DW-1:0] data_in [PM];
    logic [2:0]    space_cnt;
    logic          pop;
    logic [DW-1:0] data_out;
    logic          valid;
    logic [3:0]    count;
    logic          full;
`ifdef MULTI_PUSH_FIFO_OVF_FLAG_EN
    logic          ovf;
`endif

    multi_push_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .PUSH_MAX   (PM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push_cnt  (push_cnt),
        .data_in   (data_in),
        .space_cnt (space_cnt),
        .pop       (pop),
        .data_out  (data_out),
        .valid     (valid),
        .count     (count),
`ifdef MULTI_PUSH_FIFO_OVF_FLAG_EN
        .ovf       (ovf),
`endif
        .full      (full)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] model [$];
    bit            ovf_exp;
    int unsigned   n_total;
    int unsigned   n_bad;

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned model_space();
        int unsigned f;
        f = DEPTH - model.size();
        return (f < PM) ? f : PM;
    endfunction

    task automatic check_outputs();
        check_val("count", 32'(count), model.size());
        check_val("valid", 32'(valid), 32'(model.size() != 0));
        check_val("full", 32'(full), 32'(model.size() == DEPTH));
        check_val("space_cnt", 32'(space_cnt), model_space());
        if (model.size() != 0) check_val("data_out", 32'(data_out), 32'(model[0]));
`ifdef MULTI_PUSH_FIFO_OVF_FLAG_EN
        check_val("ovf", 32'(ovf), 32'(ovf_exp));
`endif
    endtask

    // One clock: drive at negedge, advance the model at posedge, check just after.
    task automatic step(input int unsigned pc, input bit p, input bit r);
        int unsigned space, acc;
        @(negedge clk);
        push_cnt = 3'(pc);
        pop      = p;
        rst      = r;
        for (int i = 0; i < PM; i++) data_in[i] = DW'($urandom);
        space = model_space();
        @(posedge clk);
        if (!r) begin
            model.delete();
            ovf_exp = 1'b0;
        end else begin
            if (pc > space) ovf_exp = 1'b1;
            acc = (pc < space) ? pc : space;
            if (p && model.size() != 0) void'(model.pop_front());
            for (int i = 0; i < acc; i++) model.push_back(data_in[i]);
        end
        #1;
        check_outputs();
    endtask

    initial begin
        n_total  = 0;
        n_bad    = 0;
        ovf_exp  = 1'b0;
        rst      = 1'b0;
        push_cnt = '0;
        pop      = 1'b0;
        for (int i = 0; i < PM; i++) data_in[i] = '0;

        // Reset then idle
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 1);

        // Push 3, pop 3 in order
        step(3, 0, 1);
        for (int k = 0; k < 3; k++) step(0, 1, 1);
        step(0, 1, 1);  // pop on empty is ignored

        // Fill to full, then overflow attempt
        step(4, 0, 1);
        step(4, 0, 1);
        step(2, 0, 1);

        // Fill to 6, then push 4 with pop: only pre-pop space (2) accepted
        step(0, 0, 0);
        step(4, 0, 1);
        step(2, 0, 1);
        step(4, 1, 1);
        while (model.size() != 0) step(0, 1, 1);

        // Wrap across the 7->0 boundary
        step(4, 0, 1);
        for (int k = 0; k < 3; k++) step(0, 1, 1);
        step(4, 0, 1);
        step(3, 0, 1);
        while (model.size() != 0) step(0, 1, 1);

        // Reset mid-operation with push/pop asserted
        step(4, 0, 1);
        step(1, 0, 1);
        step(4, 1, 0);
        step(0, 0, 1);

        // Random traffic with phases biased toward filling or draining
        for (int k = 0; k < 600; k++) begin
            int unsigned pop_pct;
            pop_pct = ((k / 75) % 2 == 0) ? 25 : 85;
            step($urandom_range(0, PM), ($urandom_range(0, 99) < pop_pct),
                 ($urandom_range(0, 99) != 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
